prbs_link_test_ctrl: RTL and testbench



---
 rtl/prbs_pkg.sv | 32 +++
 rtl/prbs7_word.sv | 44 ++++
 rtl/prbs_link_test_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_prbs_link_test_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS7 link test controller.
//   PRBS7_SEED  - LFSR reset/seed value
//   state_e     - controller FSM states
//   prbs7_step  - one 8-bit word step of x^7+x^6+1, returns {next_state, word}
//                 with the first generated bit in word[7]
package prbs_pkg;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SEND,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic [14:0] prbs7_step(input logic [6:0] s);
    logic [6:0] st;
    logic [7:0] w;
    logic       nb;
    st = s;
    w  = '0;
    for (int i = 7; i >= 0; i--) begin
      nb       = st[6] ^ st[5];
      st       = {st[5:0], nb};
      w[3'(i)] = nb;
    end
    return {st, w};
  endfunction

endpackage

// File: rtl/prbs7_word.sv
// PRBS7 word generator: 7-bit LFSR state register stepped a whole word at a time.
//   sys_clk, sys_rst   - clock, async active-low reset (state <= seed)
//   seed               - reload the seed value (highest priority)
//   load, load_val     - load an arbitrary state (RX self-synchronisation)
//   advance            - step the state by one word
//   word               - word produced from the current state
module prbs7_word
  import prbs_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       seed,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       advance,
  output logic [7:0] word
);

  logic [6:0]  state_q, state_d;
  logic [14:0] step;

  always_comb begin
    step    = prbs7_step(state_q);
    state_d = state_q;
    if (seed) begin
      state_d = PRBS7_SEED;
    end else if (load) begin
      state_d = load_val;
    end else if (advance) begin
      state_d = step[14:8];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= PRBS7_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign word = step[7:0];

endmodule

// File: rtl/prbs_link_test_ctrl.sv
// PRBS7 link test sequencer: streams burst_len PRBS words over valid/ready,
// then drains while a self-synchronising RX checker counts bit errors.
//   sys_clk, sys_rst         - clock, async active-low reset
//   start, abort, burst_len  - test control from the register bank
//   tx_data/tx_valid/tx_ready- serializer handshake
//   rx_data/rx_valid         - deserializer words
//   busy, done               - sequencer status, done is a one-cycle pulse
//   locked, lock_lost        - RX checker lock state / loss pulse
//   err_count, tx_count, rx_count - saturating bit errors, words sent, words checked
//
// state | meaning
// IDLE  | waiting for start; RX checker frozen
// PRIME | load first PRBS word into tx_data
// SEND  | stream words until burst_len accepted
// DRAIN | let looped-back data arrive for DRAIN_CYC cycles
// DONE  | one-cycle completion pulse
module prbs_link_test_ctrl
  import prbs_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int ERR_W     = 16,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_BITS = 3,
  parameter int DRAIN_CYC = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_count,
  output logic [LEN_W-1:0] tx_count,
  output logic [LEN_W-1:0] rx_count
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int DRN_W  = $clog2(DRAIN_CYC + 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   tx_count_q, tx_count_d, tx_count_inc;
  logic [LEN_W-1:0]   rx_count_q, rx_count_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ERR_W:0]     err_sum;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               locked_q, locked_d, lock_lost_q, lock_lost_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               tx_seed, tx_adv, rx_load, rx_adv, clr_cnt, rx_active;
  logic [7:0]         tx_word, rx_word, rx_diff;
  logic [3:0]         rx_errs;

  prbs7_word u_tx_prbs (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .seed    (tx_seed),
    .load    (1'b0),
    .load_val(7'h00),
    .advance (tx_adv),
    .word    (tx_word)
  );

  prbs7_word u_rx_prbs (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .seed    (1'b0),
    .load    (rx_load),
    .load_val(rx_data[6:0]),
    .advance (rx_adv),
    .word    (rx_word)
  );

  // Sequencer
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    tx_count_d   = tx_count_q;
    drn_d        = drn_q;
    tx_seed      = 1'b0;
    tx_adv       = 1'b0;
    clr_cnt      = 1'b0;
    tx_count_inc = tx_count_q + 1'b1;
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d      = burst_len;
            tx_count_d = '0;
            clr_cnt    = 1'b1;
            tx_seed    = 1'b1;
            state_d    = (burst_len == '0) ? ST_DONE : ST_PRIME;
          end
        end
        ST_PRIME: begin
          // LFSR always holds the state after the word sitting in tx_data.
          tx_data_d  = tx_word;
          tx_adv     = 1'b1;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
        ST_SEND: begin
          if (tx_valid_q && tx_ready) begin
            tx_count_d = tx_count_inc;
            if (tx_count_inc == len_q) begin
              tx_valid_d = 1'b0;
              drn_d      = DRN_W'(DRAIN_CYC - 1);
              state_d    = ST_DRAIN;
            end else begin
              tx_data_d = tx_word;
              tx_adv    = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drn_q == '0) begin
            state_d = ST_DONE;
          end else begin
            drn_d = drn_q - 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // RX checker
  always_comb begin
    locked_d    = locked_q;
    lock_lost_d = 1'b0;
    good_d      = good_q;
    err_d       = err_q;
    rx_count_d  = rx_count_q;
    rx_load     = 1'b0;
    rx_adv      = 1'b0;
    rx_active   = (state_q != ST_IDLE) && !abort;
    rx_diff     = rx_data ^ rx_word;
    rx_errs     = '0;
    for (int i = 0; i < 8; i++) begin
      rx_errs = rx_errs + {3'b000, rx_diff[3'(i)]};
    end
    err_sum = {1'b0, err_q} + (ERR_W + 1)'(rx_errs);
    if (clr_cnt) begin
      locked_d   = 1'b0;
      good_d     = '0;
      err_d      = '0;
      rx_count_d = '0;
    end else if (rx_active && rx_valid) begin
      if (!locked_q) begin
        // Unlocked: reseed from the received bits so the next prediction follows the line.
        rx_load = 1'b1;
        if (rx_diff == 8'h00) begin
          good_d = good_q + 1'b1;
          if (good_d == GOOD_W'(LOCK_CNT)) begin
            locked_d = 1'b1;
          end
        end else begin
          good_d = '0;
        end
      end else begin
        // Locked: free-run the prediction so line errors are counted, not absorbed.
        rx_adv = 1'b1;
        if (rx_count_q != '1) begin
          rx_count_d = rx_count_q + 1'b1;
        end
        err_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        if (rx_errs >= 4'(LOSS_BITS)) begin
          locked_d    = 1'b0;
          lock_lost_d = 1'b1;
          good_d      = '0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      err_q       <= '0;
      drn_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      good_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      err_q       <= err_d;
      drn_q       <= drn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
      good_q      <= good_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;
  assign err_count = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs_link_test_ctrl.sv
module tb_prbs_link_test_ctrl;

  localparam int PH_IDLE = 0, PH_PRIME = 1, PH_SEND = 2, PH_DRAIN = 3, PH_DONE = 4;
  localparam int NWORDS = 128;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
  logic [15:0] burst_len = '0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done, locked, lock_lost;
  logic [15:0] err_count, tx_count, rx_count;

  prbs_link_test_ctrl #(.LEN_W(16), .ERR_W(16), .LOCK_CNT(4), .LOSS_BITS(3), .DRAIN_CYC(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort), .burst_len(burst_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .done(done), .locked(locked), .lock_lost(lock_lost),
    .err_count(err_count), .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0, failures = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // PRBS word sequence from seed 7F as a bit recurrence b[n] = b[n-7] ^ b[n-6].
  logic [7:0] seq [NWORDS];
  task automatic build_seq();
    logic bits [7 + 8*NWORDS];
    for (int n = 0; n < 7; n++) bits[n] = 1'b1;
    for (int n = 7; n < 7 + 8*NWORDS; n++) bits[n] = bits[n-7] ^ bits[n-6];
    for (int w = 0; w < NWORDS; w++)
      for (int b = 0; b < 8; b++) seq[w][7-b] = bits[7 + 8*w + b];
  endtask

  // Predict the next word continuing the recurrence from a 7-bit history (h[6] oldest).
  function automatic logic [7:0] pred_word(input logic [6:0] h, output logic [6:0] nh);
    logic y [15];
    logic [7:0] w;
    for (int k = 0; k < 7; k++) y[k] = h[6-k];
    for (int k = 7; k < 15; k++) y[k] = y[k-7] ^ y[k-6];
    for (int k = 0; k < 8; k++) w[7-k] = y[7+k];
    for (int k = 0; k < 7; k++) nh[6-k] = y[8+k];
    return w;
  endfunction

  // Behavioural model
  int         m_phase = PH_IDLE, m_len = 0, m_txc = 0, m_drain = 0;
  int         m_err = 0, m_rxc = 0, m_good = 0;
  bit         m_valid = 0, m_locked = 0, m_lost = 0;
  logic [6:0] m_hist = 7'h7F;

  task automatic model_step();
    logic [7:0] pw;
    logic [6:0] nh;
    int e;
    m_lost = 0;
    if (m_phase == PH_IDLE) begin
      if (start) begin m_locked = 0; m_good = 0; m_err = 0; m_rxc = 0; end
    end else if (!abort && rx_valid) begin
      pw = pred_word(m_hist, nh);
      if (!m_locked) begin
        m_good = (rx_data == pw) ? m_good + 1 : 0;
        m_hist = rx_data[6:0];
        if (m_good == 4) m_locked = 1;
      end else begin
        e = $countones(rx_data ^ pw);
        m_rxc = (m_rxc + 1 > 65535) ? 65535 : m_rxc + 1;
        m_err = (m_err + e > 65535) ? 65535 : m_err + e;
        m_hist = nh;
        if (e >= 3) begin m_locked = 0; m_lost = 1; m_good = 0; end
      end
    end
    if (m_phase == PH_IDLE) begin
      if (start) begin
        m_len = int'(burst_len); m_txc = 0;
        m_phase = (burst_len == 0) ? PH_DONE : PH_PRIME;
      end
    end else if (abort) begin
      m_phase = PH_IDLE; m_valid = 0;
    end else begin
      case (m_phase)
        PH_PRIME: begin m_valid = 1; m_phase = PH_SEND; end
        PH_SEND: if (m_valid && tx_ready) begin
          m_txc++;
          if (m_txc == m_len) begin m_valid = 0; m_phase = PH_DRAIN; m_drain = 16; end
        end
        PH_DRAIN: begin m_drain--; if (m_drain == 0) m_phase = PH_DONE; end
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(posedge sys_clk or negedge sys_rst);
    if (!sys_rst) begin
      m_phase = PH_IDLE; m_len = 0; m_txc = 0; m_drain = 0; m_err = 0; m_rxc = 0;
      m_good = 0; m_valid = 0; m_locked = 0; m_lost = 0; m_hist = 7'h7F;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(m_phase != PH_IDLE));
      check("done", 32'(done), 32'(m_phase == PH_DONE));
      check("tx_valid", 32'(tx_valid), 32'(m_valid));
      check("tx_count", 32'(tx_count), m_txc);
      check("locked", 32'(locked), 32'(m_locked));
      check("lock_lost", 32'(lock_lost), 32'(m_lost));
      check("err_count", 32'(err_count), m_err);
      check("rx_count", 32'(rx_count), m_rxc);
      if (m_valid) check("tx_data", 32'(tx_data), 32'(seq[m_txc]));
    end
  end

  // Loopback: words accepted downstream reappear on rx one cycle later, optionally corrupted.
  logic       lb_en = 1'b0, s_hs = 1'b0;
  logic [7:0] s_d = 8'h00, mask1 = 8'h00, mask2 = 8'h00;
  int         lb_k = 0, flip1 = -1, flip2 = -1, lost_cnt = 0;

  initial forever begin
    @(negedge sys_clk);
    if (lock_lost) lost_cnt++;
    s_hs = lb_en && tx_valid && tx_ready;
    s_d  = tx_data;
    if (!lb_en) lb_k = 0;
    if (s_hs) begin
      if (lb_k == flip1) s_d = s_d ^ mask1;
      else if (lb_k == flip2) s_d = s_d ^ mask2;
      lb_k++;
    end
  end

  initial forever begin
    @(posedge sys_clk);
    #1;
    rx_valid = s_hs;
    rx_data  = s_hs ? s_d : 8'h00;
  end

  task automatic step_clk();
    @(posedge sys_clk); #1;
  endtask

  task automatic pulse_start(input int len);
    step_clk();
    burst_len = 16'(len); start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin @(negedge sys_clk); n++; end
    if (done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done expected=done within %0d cycles", tag, max);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_tx_count"}, 32'(tx_count), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_lock_lost"}, 32'(lock_lost), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_rx_count"}, 32'(rx_count), 0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
  endtask

  initial begin
    int n, dcnt;
    build_seq();
    check("seq_pin_w0", 32'(seq[0]), 32'h02);
    check("seq_pin_w3", 32'(seq[3]), 32'hF2);
    cmp_en = 1'b1;
    @(negedge sys_clk);
    check_outputs_zero("reset");
    step_clk();
    sys_rst = 1'b1;

    // Basic burst of 2
    tx_ready = 1'b1;
    pulse_start(2);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("t1_word0", 32'(tx_data), 32'h02);
    @(negedge sys_clk);
    check("t1_word1", 32'(tx_data), 32'h0C);
    wait_done("t1", 40, n);
    check("t1_drain_to_done", n, 17);
    check("t1_tx_count", 32'(tx_count), 2);

    // Mid-burst stall
    pulse_start(8);
    n = 0;
    while (tx_count != 16'd3 && n < 30) begin @(negedge sys_clk); n++; end
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("t2_stall_data", 32'(tx_data), 32'hF2);
      check("t2_stall_valid", 32'(tx_valid), 1);
      check("t2_stall_count", 32'(tx_count), 3);
    end
    tx_ready = 1'b1;
    @(negedge sys_clk);
    check("t2_after_stall_count", 32'(tx_count), 4);
    wait_done("t2", 60, n);
    check("t2_tx_count", 32'(tx_count), 8);

    // Clean loopback, 100 words
    step_clk();
    lb_en = 1'b1; lost_cnt = 0;
    pulse_start(100);
    wait_done("t3", 200, n);
    check("t3_rx_count", 32'(rx_count), 96);
    check("t3_err_count", 32'(err_count), 0);
    check("t3_locked", 32'(locked), 1);
    check("t3_lost_cnt", lost_cnt, 0);

    // Loopback with injected bit errors
    step_clk();
    lb_en = 1'b0;
    do_reset();
    flip1 = 20; mask1 = 8'h01; flip2 = 40; mask2 = 8'h83;
    lb_en = 1'b1; lost_cnt = 0;
    pulse_start(100);
    n = 0;
    while (err_count == 16'd0 && n < 100) begin @(negedge sys_clk); n++; end
    check("t4_err_after_1bit", 32'(err_count), 1);
    n = 0;
    while (lock_lost !== 1'b1 && n < 100) begin @(negedge sys_clk); n++; end
    check("t4_err_at_loss", 32'(err_count), 4);
    check("t4_lock_lost_pulse", 32'(lock_lost), 1);
    wait_done("t4", 200, n);
    check("t4_err_final", 32'(err_count), 4);
    check("t4_rx_count", 32'(rx_count), 92);
    check("t4_relocked", 32'(locked), 1);
    check("t4_lost_cnt", lost_cnt, 1);
    step_clk();
    lb_en = 1'b0; flip1 = -1; flip2 = -1;

    // Abort at tx_count = 10
    pulse_start(20);
    n = 0;
    while (tx_count != 16'd10 && n < 40) begin @(negedge sys_clk); n++; end
    tx_ready = 1'b0; abort = 1'b1;
    step_clk();
    abort = 1'b0; tx_ready = 1'b1;
    @(negedge sys_clk);
    check("t5_busy", 32'(busy), 0);
    check("t5_tx_valid", 32'(tx_valid), 0);
    check("t5_tx_count", 32'(tx_count), 10);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin @(negedge sys_clk); if (done) dcnt++; end
    check("t5_no_done", dcnt, 0);
    pulse_start(3);
    @(negedge sys_clk);
    check("t5_restart_count", 32'(tx_count), 0);
    check("t5_restart_busy", 32'(busy), 1);
    wait_done("t5", 40, n);
    check("t5_restart_final", 32'(tx_count), 3);

    // Zero-length burst
    pulse_start(0);
    @(negedge sys_clk);
    check("t6_zero_done", 32'(done), 1);
    check("t6_zero_valid", 32'(tx_valid), 0);
    @(negedge sys_clk);
    check("t6_zero_done_gone", 32'(done), 0);
    check("t6_zero_idle", 32'(busy), 0);

    // Reset mid-SEND
    pulse_start(50);
    repeat (5) @(negedge sys_clk);
    check("t6_sending", 32'(tx_valid), 1);
    #2 sys_rst = 1'b0;
    #1 check_outputs_zero("t6_midrst");
    step_clk();
    step_clk();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
